// File: rtl/qr_norm_ctrl.sv
// qr_norm_ctrl: streams signed vector elements, accumulates their squares and returns the
// 2-norm through an external stallable sqrt pipe.
// Build option: define QR_NORM_SAT_EN to saturate the sum of squares and flag overflow;
// without it the sum wraps modulo 2^ACC_W and norm_ovf stays 0.
module qr_norm_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ACC_W       = 33,
    parameter int MAX_LEN     = 8,
    parameter int SQRT_STAGES = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_last,
    output logic [ACC_W-1:0]       sq_a,
    output logic                   sq_en,
    input  logic [(ACC_W+1)/2-1:0] sq_root,
    output logic                   norm_valid,
    input  logic                   norm_ready,
    output logic [(ACC_W+1)/2-1:0] norm_data,
    output logic [3:0]             norm_cnt,
    output logic                   norm_ovf
);
    logic [DATA_W-1:0]      mag;
    logic [2*DATA_W-1:0]    sq;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_nx;
    logic [3:0]             cnt;
    logic [3:0]             cnt_nx;
    logic                   ovf_nx;
    logic                   take;
    logic                   last;
    logic [SQRT_STAGES-1:0] tok;
    logic [3:0]             tok_cnt [SQRT_STAGES];
    logic                   tok_ovf [SQRT_STAGES];

    // The whole datapath, sqrt pipe included, advances only when the output slot can move
    assign sq_en    = !norm_valid || norm_ready;
    assign in_ready = sq_en;
    assign take     = in_valid && sq_en;
    assign cnt_nx   = cnt + 4'd1;
    assign last     = in_last || cnt_nx == 4'(MAX_LEN);
    assign mag      = in_data[DATA_W-1] ? ~in_data + DATA_W'(1) : in_data;
    assign sq       = {{DATA_W{1'b0}}, mag} * {{DATA_W{1'b0}}, mag};

`ifdef QR_NORM_SAT_EN
    logic [ACC_W:0] sum;
    logic           ovf;

    assign sum    = {1'b0, acc} + (ACC_W+1)'(sq);
    assign acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    assign ovf_nx = ovf || sum[ACC_W];

    // Sticky overflow flag of the vector being accumulated, cleared when it issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (take)
            ovf <= last ? 1'b0 : ovf_nx;
    end
`else
    assign acc_nx = acc + ACC_W'(sq);
    assign ovf_nx = 1'b0;
`endif

    // Accumulate, issue to the sqrt pipe, shift in-flight tokens and register the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            sq_a       <= '0;
            tok        <= '0;
            for (int i = 0; i < SQRT_STAGES; i++) begin
                tok_cnt[i] <= '0;
                tok_ovf[i] <= 1'b0;
            end
            norm_valid <= 1'b0;
            norm_data  <= '0;
            norm_cnt   <= '0;
            norm_ovf   <= 1'b0;
        end else if (sq_en) begin
            if (take) begin
                acc <= last ? '0 : acc_nx;
                cnt <= last ? '0 : cnt_nx;
                if (last)
                    sq_a <= acc_nx;
            end
            tok[0]     <= take && last;
            tok_cnt[0] <= cnt_nx;
            tok_ovf[0] <= ovf_nx;
            for (int i = 1; i < SQRT_STAGES; i++) begin
                tok[i]     <= tok[i-1];
                tok_cnt[i] <= tok_cnt[i-1];
                tok_ovf[i] <= tok_ovf[i-1];
            end
            norm_valid <= tok[SQRT_STAGES-1];
            if (tok[SQRT_STAGES-1]) begin
                norm_data <= sq_root;
                norm_cnt  <= tok_cnt[SQRT_STAGES-1];
                norm_ovf  <= tok_ovf[SQRT_STAGES-1];
            end
        end
    end
endmodule
